// File: rtl/dvsd_div_pkg.sv
// rtl/dvsd_div_pkg.sv - shared widths, state encoding and constants for the restoring divider
package dvsd_div_pkg;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam logic [15:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dvsd_divstep.sv
// rtl/dvsd_divstep.sv - one restoring-division step: shift in a dividend bit, trial-subtract divisor
module dvsd_divstep
  import dvsd_div_pkg::*;
#(
  parameter int W = VW
) (
  input  logic [W-1:0] pr,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] pr_next,
  output logic         qbit
);

  logic [W:0] pr9;
  logic [W:0] diff;

  // One extra bit so the shifted partial remainder can exceed the divisor range
  assign pr9     = {pr, msb};
  assign diff    = pr9 - {1'b0, divisor};
  assign qbit    = (pr9 >= {1'b0, divisor});
  assign pr_next = qbit ? diff[W-1:0] : pr9[W-1:0];

endmodule

// File: rtl/dvsd_1682d.sv
// rtl/dvsd_1682d.sv - iterative 16/8 restoring divider, one quotient bit per clock
module dvsd_1682d
  import dvsd_div_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state, state_next;
  logic [DW-1:0] dq;
  logic [VW-1:0] pr;
  logic [VW-1:0] div_r;
  logic [CW-1:0] cnt;
  logic [VW-1:0] pr_next;
  logic          qbit;

  dvsd_divstep #(.W(VW)) u_step (
    .pr      (pr),
    .msb     (dq[DW-1]),
    .divisor (div_r),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor != '0) ? CALC : DONE;
      CALC: if (cnt == LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dq        <= '0;
      pr        <= '0;
      div_r     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dq    <= dividend;
            div_r <= divisor;
            pr    <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          dq  <= {dq[DW-2:0], qbit};
          pr  <= pr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= {dq[DW-2:0], qbit};
            remainder <= pr_next;
            dbz       <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          // Divide-by-zero skips CALC; its results are published on the way out of DONE
          if (div_r == '0) begin
            quotient  <= DW'(DBZ_QUOTIENT);
            remainder <= dq[VW-1:0];
            dbz       <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
